// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard unit.
// Holds the select encodings, the shadow-stage record and the select-priority helper.
package fwd_pkg;

    localparam int FWD_ADDR_W = 5;
    localparam int FWD_SEL_W  = 2;

    localparam logic [FWD_SEL_W-1:0]  FWD_RF    = 2'b00;
    localparam logic [FWD_SEL_W-1:0]  FWD_EXMEM = 2'b10;
    localparam logic [FWD_SEL_W-1:0]  FWD_MEMWB = 2'b01;
    localparam logic [FWD_ADDR_W-1:0] REG_ZERO  = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [FWD_ADDR_W-1:0] dst;
        logic                  reg_write;
        logic                  mem_read;
    } stage_info_t;

    localparam stage_info_t STAGE_EMPTY = '{valid: 1'b0, dst: REG_ZERO, reg_write: 1'b0, mem_read: 1'b0};

    // Youngest producer first: ex is about to move to EX/MEM, mem to MEM/WB.
    function automatic logic [FWD_SEL_W-1:0] fwd_select(
        input logic                  enable,
        input logic [FWD_ADDR_W-1:0] src,
        input stage_info_t           ex,
        input stage_info_t           mem
    );
        logic [FWD_SEL_W-1:0] sel;
        if (!enable || (src == REG_ZERO)) begin
            sel = FWD_RF;
        end else if (ex.valid && ex.reg_write && (ex.dst == src)) begin
            sel = FWD_EXMEM;
        end else if (mem.valid && mem.reg_write && (mem.dst == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding unit: ID-stage info and controls in,
// forward selects and stall/bubble out. master = pipeline, slave = hazard unit.
interface fwd_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
);
    logic                  ext_hold;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic [SEL_W-1:0]      forward_a;
    logic [SEL_W-1:0]      forward_b;
    logic                  stall;
    logic                  bubble;

    modport master (
        output ext_hold, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dst, id_reg_write, id_mem_read,
        input  forward_a, forward_b, stall, bubble
    );

    modport slave (
        input  ext_hold, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dst, id_reg_write, id_mem_read,
        output forward_a, forward_b, stall, bubble
    );
endinterface

// File: rtl/fwd_stage_reg.sv
// One shadow pipeline-stage register (valid/dst/reg_write/mem_read) with
// freeze (hold) and squash (bubble) controls.
module fwd_stage_reg
    import fwd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        bubble,
    input  stage_info_t d,
    output stage_info_t q
);

    stage_info_t stage_d;
    stage_info_t stage_q;

    // Next-state select: freeze, squash, or take the upstream stage.
    always_comb begin
        stage_d = stage_q;
        if (hold) begin
            stage_d = stage_q;
        end else if (bubble) begin
            stage_d = STAGE_EMPTY;
        end else begin
            stage_d = d;
        end
    end

    // Stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= STAGE_EMPTY;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forward-select generator and load-use hazard detector for the 5-stage pipeline.
// Optional performance counters (stall_cnt, fwd_cnt) are built when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = fwd_pkg::FWD_ADDR_W,
    parameter int SEL_W      = fwd_pkg::FWD_SEL_W
`ifdef FWD_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_unit_if.slave   bus
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   fwd_cnt
`endif
);

    logic [REG_ADDR_W-1:0] id_rs_s;
    logic [REG_ADDR_W-1:0] id_rt_s;
    stage_info_t           id_info_s;
    stage_info_t           s1_q;
    stage_info_t           s2_q;
    stage_info_t           s3_q;
    logic                  hazard_s;
    logic                  stall_s;
    logic                  bubble_s;
    logic [SEL_W-1:0]      forward_a_d;
    logic [SEL_W-1:0]      forward_b_d;
    logic [SEL_W-1:0]      forward_a_q;
    logic [SEL_W-1:0]      forward_b_q;
    logic                  unused_s3_s;

    assign id_rs_s = bus.id_rs;
    assign id_rt_s = bus.id_rt;

    // ID-stage record and load-use detection; flush overrides the stall.
    always_comb begin
        id_info_s = '{valid: bus.id_valid, dst: bus.id_dst,
                      reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
        hazard_s  = bus.id_valid && s1_q.valid && s1_q.mem_read && (s1_q.dst != REG_ZERO) &&
                    ((bus.id_uses_rs && (id_rs_s == s1_q.dst)) ||
                     (bus.id_uses_rt && (id_rt_s == s1_q.dst)));
        stall_s   = hazard_s && !bus.flush;
        bubble_s  = stall_s || bus.flush;
    end

    fwd_stage_reg u_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (bus.ext_hold),
        .bubble (bubble_s),
        .d      (id_info_s),
        .q      (s1_q)
    );

    fwd_stage_reg u_s2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (bus.ext_hold),
        .bubble (1'b0),
        .d      (s1_q),
        .q      (s2_q)
    );

    fwd_stage_reg u_s3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (bus.ext_hold),
        .bubble (1'b0),
        .d      (s2_q),
        .q      (s3_q)
    );

    // MEM/WB shadow is kept for completeness of the pipeline image only.
    assign unused_s3_s = ^s3_q;

    // Selects are computed against s1/s2 now, since they will be EX/MEM and MEM/WB next cycle.
    always_comb begin
        forward_a_d = forward_a_q;
        forward_b_d = forward_b_q;
        if (bus.ext_hold) begin
            forward_a_d = forward_a_q;
            forward_b_d = forward_b_q;
        end else begin
            forward_a_d = fwd_select(bus.id_valid && bus.id_uses_rs && !bubble_s, id_rs_s, s1_q, s2_q);
            forward_b_d = fwd_select(bus.id_valid && bus.id_uses_rt && !bubble_s, id_rt_s, s1_q, s2_q);
        end
    end

    // Forward-select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            forward_a_q <= FWD_RF;
            forward_b_q <= FWD_RF;
        end else begin
            forward_a_q <= forward_a_d;
            forward_b_q <= forward_b_d;
        end
    end

    assign bus.forward_a = forward_a_q;
    assign bus.forward_b = forward_b_q;
    assign bus.stall     = stall_s;
    assign bus.bubble    = bubble_s;

`ifdef FWD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q;

    // Saturating event counters, advancing edges only.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (!bus.ext_hold && stall_s && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!bus.ext_hold && ((forward_a_d != FWD_RF) || (forward_b_d != FWD_RF)) && !(&fwd_cnt_q)) begin
            fwd_cnt_d = fwd_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            fwd_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed table-driven bench for fwd_hazard_unit: instruction stream with hand-computed
// stall/bubble (checked before the edge) and forward selects (checked after the edge).
module tb_fwd_hazard_unit;

`ifdef FWD_PERF_CNT_EN
    localparam int TB_CNT_W = 3;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fwd_hazard_unit_if #(.REG_ADDR_W(5), .SEL_W(2)) bus ();

`ifdef FWD_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] fwd_cnt;

    fwd_hazard_unit #(.REG_ADDR_W(5), .SEL_W(2), .CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
    );
`else
    fwd_hazard_unit #(.REG_ADDR_W(5), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
`endif

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       hd;
        int         e_stall;
        int         e_bubble;
        int         e_fa;
        int         e_fb;
    } vec_t;

    vec_t vq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_row(input int valid, input int rs, input int rt, input int urs, input int urt,
                           input int dst, input int rw, input int mr, input int fl, input int hd,
                           input int es, input int eb, input int efa, input int efb);
        vec_t v;
        v.valid = valid[0]; v.rs = rs[4:0]; v.rt = rt[4:0]; v.urs = urs[0]; v.urt = urt[0];
        v.dst = dst[4:0]; v.rw = rw[0]; v.mr = mr[0]; v.fl = fl[0]; v.hd = hd[0];
        v.e_stall = es; v.e_bubble = eb; v.e_fa = efa; v.e_fb = efb;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid     = v.valid;
        bus.id_rs        = v.rs;
        bus.id_rt        = v.rt;
        bus.id_uses_rs   = v.urs;
        bus.id_uses_rt   = v.urt;
        bus.id_dst       = v.dst;
        bus.id_reg_write = v.rw;
        bus.id_mem_read  = v.mr;
        bus.flush        = v.fl;
        bus.ext_hold     = v.hd;
    endtask

    // Called #1 after a rising edge: drive, check combinational outputs, clock, check selects.
    task automatic apply(input string tag, input vec_t v);
        drive(v);
        #1;
        check({tag, " stall"},  int'(bus.stall),  v.e_stall);
        check({tag, " bubble"}, int'(bus.bubble), v.e_bubble);
        @(posedge clk);
        #1;
        check({tag, " forward_a"}, int'(bus.forward_a), v.e_fa);
        check({tag, " forward_b"}, int'(bus.forward_b), v.e_fb);
    endtask

    // Load-use group: lw r2,0(r1) ; add r4,r2,r1 (stalled) ; add r4,r2,r1 (gets MEM/WB).
    task automatic load_use_group(input string tag);
        vec_t v;
        v = '{1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
        apply({tag, " lw"}, v);
        v = '{1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0};
        apply({tag, " use"}, v);
        v = '{1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0};
        apply({tag, " resume"}, v);
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;
        v = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        drive(v);
        rst_n = 1'b0;

        //      vld rs  rt urs urt dst rw mr fl hd  st bu fa fb
        add_row(1,  1,  2, 1, 1,  3,  1, 0, 0, 0,  0, 0, 0, 0); // add r3,r1,r2
        add_row(1,  3,  4, 1, 1,  5,  1, 0, 0, 0,  0, 0, 2, 0); // sub r5,r3,r4 -> EX/MEM
        add_row(1,  1,  2, 1, 1,  7,  1, 0, 0, 0,  0, 0, 0, 0); // and r7,r1,r2
        add_row(1,  5,  0, 1, 1,  8,  1, 0, 0, 0,  0, 0, 1, 0); // or r8,r5,r0 -> MEM/WB
        add_row(1,  1,  1, 1, 1,  3,  1, 0, 0, 0,  0, 0, 0, 0); // add r3
        add_row(1,  1,  2, 1, 1,  3,  1, 0, 0, 0,  0, 0, 0, 0); // add r3 again
        add_row(1,  3,  3, 1, 1,  6,  1, 0, 0, 0,  0, 0, 2, 2); // or r6,r3,r3 youngest wins
        add_row(1,  1,  2, 1, 1,  0,  1, 0, 0, 0,  0, 0, 0, 0); // add r0,r1,r2
        add_row(1,  0,  0, 1, 1,  9,  1, 0, 0, 0,  0, 0, 0, 0); // sub r9,r0,r0 never forwarded
        add_row(1,  1,  0, 1, 0,  2,  1, 1, 0, 0,  0, 0, 0, 0); // lw r2,0(r1)
        add_row(1,  2,  1, 1, 1,  4,  1, 0, 0, 0,  1, 1, 0, 0); // add r4,r2,r1 load-use
        add_row(1,  2,  1, 1, 1,  4,  1, 0, 0, 0,  0, 0, 1, 0); // same, now MEM/WB
        add_row(1,  1,  0, 1, 0,  2,  1, 1, 0, 0,  0, 0, 0, 0); // lw r2,0(r1)
        add_row(1,  2,  1, 1, 1,  4,  1, 0, 1, 0,  0, 1, 0, 0); // load-use under flush
        add_row(1,  2,  4, 1, 1, 10,  1, 0, 0, 0,  0, 0, 1, 0); // xor r10,r2,r4 (r4 squashed)
        add_row(1,  1,  0, 1, 0,  0,  1, 1, 0, 0,  0, 0, 0, 0); // lw r0
        add_row(1,  0,  1, 1, 1, 11,  1, 0, 0, 0,  0, 0, 0, 0); // add r11,r0,r1 no stall
        add_row(0, 11,  0, 1, 1,  3,  1, 0, 0, 0,  0, 0, 0, 0); // invalid ID slot
        add_row(1, 11,  2, 0, 1, 12,  1, 0, 0, 0,  0, 0, 0, 0); // rs not used
        add_row(1,  1,  2, 1, 1, 13,  1, 0, 0, 0,  0, 0, 0, 0); // add r13
        add_row(1, 13,  1, 1, 1, 14,  1, 0, 0, 0,  0, 0, 2, 0); // sub r14,r13,r1
        add_row(1, 14,  2, 1, 1, 15,  1, 0, 0, 1,  0, 0, 2, 0); // held
        add_row(1, 14,  2, 1, 1, 15,  1, 0, 0, 1,  0, 0, 2, 0); // held
        add_row(1, 14,  2, 1, 1, 15,  1, 0, 0, 1,  0, 0, 2, 0); // held
        add_row(1, 13, 14, 1, 1, 15,  1, 0, 0, 0,  0, 0, 1, 2); // resume: r13 MEM/WB, r14 EX/MEM

        #12;
        check("reset forward_a", int'(bus.forward_a), 0);
        check("reset forward_b", int'(bus.forward_b), 0);
        check("reset stall",     int'(bus.stall),     0);
`ifdef FWD_PERF_CNT_EN
        check("reset stall_cnt", int'(stall_cnt), 0);
        check("reset fwd_cnt",   int'(fwd_cnt),   0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            apply($sformatf("row%0d", i), vq[i]);
        end

        // Mid-stream reset while a load-use stall is pending and a forward select is live.
        v = '{1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        apply("mid add r2", v);
        v = '{1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 2, 0};
        apply("mid lw r5", v);
        v = '{1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
        drive(v);
        #1;
        check("mid pre-reset stall", int'(bus.stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset forward_a", int'(bus.forward_a), 0);
        check("mid reset forward_b", int'(bus.forward_b), 0);
        check("mid reset stall",     int'(bus.stall),     0);
        check("mid reset bubble",    int'(bus.bubble),    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef FWD_PERF_CNT_EN
        check("post reset stall_cnt", int'(stall_cnt), 0);
        check("post reset fwd_cnt",   int'(fwd_cnt),   0);
        for (int g = 0; g < 4; g++) begin
            load_use_group($sformatf("cnt%0d", g));
        end
        check("stall_cnt after 4", int'(stall_cnt), 4);
        check("fwd_cnt after 4",   int'(fwd_cnt),   4);
        for (int g = 4; g < 9; g++) begin
            load_use_group($sformatf("cnt%0d", g));
        end
        check("stall_cnt saturated", int'(stall_cnt), 7);
        check("fwd_cnt saturated",   int'(fwd_cnt),   7);
`else
        load_use_group("lu");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
